// File: rtl/alu_pkg.sv
// Shared opcode encoding, handshake FSM states and opcode classification
// for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SLTU  = 5'b00101;
    localparam logic [4:0] OP_SLL   = 5'b00110;
    localparam logic [4:0] OP_SRL   = 5'b00111;
    localparam logic [4:0] OP_SRA   = 5'b01000;
    localparam logic [4:0] OP_SLT   = 5'b01001;
    localparam logic [4:0] OP_MUL   = 5'b01010;
    localparam logic [4:0] OP_MULHU = 5'b01011;
    localparam logic [4:0] OP_DIVU  = 5'b01100;
    localparam logic [4:0] OP_REMU  = 5'b01101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [4:0] opcode);
        return (opcode == OP_MUL) || (opcode == OP_MULHU) ||
               (opcode == OP_DIVU) || (opcode == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// One-bit-per-cycle unsigned shift-add multiplier and restoring divider
// sharing a single 2*WIDTH accumulator. op[1]=0 multiply, op[1]=1 divide.
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   opnd, mul_add, rem_diff;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [CW-1:0]      cnt;
    logic               running, is_div, rem_ge;
    logic               unused_op;

    // op[0] only chooses hi/lo, which the caller does itself.
    assign unused_op = op[0];

    // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, quotient}.
    // A zero divisor naturally yields an all-ones quotient and remainder = dividend.
    always_comb begin
        mul_add  = acc[0] ? opnd : '0;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, opnd};
        rem_diff = rem_sh[WIDTH-1:0] - opnd;
        if (is_div)
            acc_next = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};
        else
            acc_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Final step result is presented alongside done so the caller can latch it that edge.
    assign done = running && (cnt == '0);
    assign hi   = acc_next[2*WIDTH-1:WIDTH];
    assign lo   = acc_next[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            running <= 1'b0;
            is_div  <= 1'b0;
        end else if (start) begin
            acc     <= op[1] ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            opnd    <= op[1] ? b : a;
            is_div  <= op[1];
            cnt     <= CW'(WIDTH - 1);
            running <= 1'b1;
        end else if (running) begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops complete in one cycle, MUL/MULHU/DIVU/REMU
// iterate one bit per cycle. Result is registered and held until consumed.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] operand_0,
    input  logic [WIDTH-1:0] operand_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    // Transfer on in_valid && in_ready (input) and out_valid && out_ready (output);
    // in_ready is combinational on out_ready so DONE can accept back-to-back.
    state_t           state, state_next;
    logic             accept, iter_op, start, sel_hi, md_done;
    logic [1:0]       md_op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_out, md_hi, md_lo;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_BUSY);
    assign accept    = in_valid && in_ready;
    assign iter_op   = is_iterative(opcode);
    assign start     = accept && iter_op;
    // MUL/MULHU/DIVU/REMU -> 0/1/2/3: bit 1 selects divide, bit 0 selects the high half.
    assign md_op     = opcode[1:0] ^ 2'b10;
    assign shamt     = operand_1[SHW-1:0];

    always_comb begin
        alu_out = '0;
        case (opcode)
            OP_ADD:  alu_out = operand_0 + operand_1;
            OP_SUB:  alu_out = operand_0 - operand_1;
            OP_AND:  alu_out = operand_0 & operand_1;
            OP_OR:   alu_out = operand_0 | operand_1;
            OP_XOR:  alu_out = operand_0 ^ operand_1;
            OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (operand_0 < operand_1)};
            OP_SLL:  alu_out = operand_0 << shamt;
            OP_SRL:  alu_out = operand_0 >> shamt;
            OP_SRA:  alu_out = $signed(operand_0) >>> shamt;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(operand_0) < $signed(operand_1))};
            default: alu_out = '0;
        endcase
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (md_op),
        .a     (operand_0),
        .b     (operand_1),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = iter_op ? S_BUSY : S_DONE;
            S_BUSY:  if (md_done) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = accept ? (iter_op ? S_BUSY : S_DONE) : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            sel_hi <= 1'b0;
        end else begin
            if (accept && !iter_op)
                result <= alu_out;
            else if (busy && md_done)
                result <= sel_hi ? md_hi : md_lo;
            if (start)
                sel_hi <= md_op[0];
        end
    end

endmodule
